// File: rtl/mem_access_unit.sv
// Initiator side of the 256x8 data memory port: LOAD/STORE/PUSH/POP with an owned stack pointer.
// Define STACK_GUARD_EN to flag stack overflow/underflow on resp_err instead of wrapping sp.
module mem_access_unit #(
    parameter logic [7:0] SP_INIT  = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic [7:0] sp,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    // state  | meaning
    // IDLE   | ready for a request
    // ACCESS | drive memory port for one cycle
    // RESP   | hold response until resp_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;
    localparam logic [1:0] OP_POP   = 2'd3;

`ifdef STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [1:0] op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] resp_data_q, resp_data_d;
    logic       resp_err_q, resp_err_d;
    logic       guard_hit;

    assign guard_hit = ((req_op == OP_PUSH) && (sp_q == SP_LIMIT)) ||
                       ((req_op == OP_POP)  && (sp_q == SP_INIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sp_q        <= SP_INIT;
            op_q        <= 2'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            resp_data_q <= 8'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wdata   = 8'd0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    data_d = req_data;
                    if (GUARD_EN && guard_hit) begin
                        // Guard errors skip the memory entirely and leave sp untouched.
                        state_d     = RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = 8'd0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                case (op_q)
                    OP_LOAD: begin
                        mem_addr    = addr_q;
                        resp_data_d = mem_rdata;
                    end
                    OP_STORE: begin
                        mem_addr  = addr_q;
                        mem_wr_en = 1'b1;
                        mem_wdata = data_q;
                    end
                    OP_PUSH: begin
                        mem_addr  = sp_q - 8'd1;
                        mem_wr_en = 1'b1;
                        mem_wdata = data_q;
                        sp_d      = sp_q - 8'd1;
                    end
                    default: begin
                        mem_addr    = sp_q;
                        resp_data_d = mem_rdata;
                        sp_d        = sp_q + 8'd1;
                    end
                endcase
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d     = IDLE;
                    resp_data_d = 8'd0;
                    resp_err_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_data = resp_data_q;
    assign resp_err  = GUARD_EN ? resp_err_q : 1'b0;
    assign sp        = sp_q;

endmodule
